// File: rtl/cpu_types_pkg.sv
// Shared fetch/decode types: skid-buffer state encoding and the payload record
// whose packed width sets the default pipeline-stage width.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplusfour;
    } fd_payload_t;

    localparam int unsigned FD_WIDTH = $bits(fd_payload_t);

endpackage

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between fetch and decode. in_ready depends on the state
// only, so there is no combinational path from out_ready back to in_ready.
module pipe_stage_buf
    import cpu_types_pkg::*;
#(
    parameter int unsigned      WIDTH  = FD_WIDTH,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire, out_fire;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_valid ? main_q : BUBBLE;
    assign occupancy = (state_q == TWO) ? 2'd2 : (state_q == ONE) ? 2'd1 : 2'd0;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    case ({in_fire, out_fire})
                        2'b11: main_d = in_data;
                        2'b10: begin
                            state_d = TWO;
                            skid_d  = in_data;
                        end
                        2'b01: state_d = EMPTY;
                        default: ;
                    endcase
                end
                TWO: begin
                    // Skid entry moves up; input is blocked because in_ready=0 here.
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers are masked by out_valid, so they need no reset.
    always_ff @(posedge CLK) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed vector table plus a randomized handshake run checked against a
// queue model of the expected buffer contents.
module tb_pipe_stage_buf;

    localparam int unsigned W = 96;

    logic         CLK = 1'b0;
    logic         RST;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_buf #(.WIDTH(W), .BUBBLE('0)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       fl;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       ov;
        logic       ir;
        logic [1:0] occ;
        logic [7:0] od;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic fl, input logic iv, input logic [7:0] d,
                       input logic ordy, input logic ov, input logic ir, input logic [1:0] occ,
                       input logic [7:0] od);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ov = ov; v.ir = ir; v.occ = occ; v.od = od;
        vq.push_back(v);
    endtask

    logic [W-1:0] model_q[$];
    logic [W-1:0] rdata;
    logic         m_in_fire, m_out_fire;

    initial begin
        // rst fl iv d ordy | ov ir occ od  (outputs checked just after the edge)
        add(1, 0, 1, 8'hAA, 0,  0, 1, 0, 8'h00);
        add(1, 0, 1, 8'hAA, 0,  0, 1, 0, 8'h00);
        // back-to-back streaming
        add(0, 0, 1, 8'h01, 1,  1, 1, 1, 8'h01);
        add(0, 0, 1, 8'h02, 1,  1, 1, 1, 8'h02);
        add(0, 0, 1, 8'h03, 1,  1, 1, 1, 8'h03);
        add(0, 0, 1, 8'h04, 1,  1, 1, 1, 8'h04);
        add(0, 0, 1, 8'h05, 1,  1, 1, 1, 8'h05);
        add(0, 0, 0, 8'h00, 1,  0, 1, 0, 8'h00);
        // stall fills skid, third push refused, release drains in order
        add(0, 0, 1, 8'h10, 0,  1, 1, 1, 8'h10);
        add(0, 0, 1, 8'h11, 0,  1, 0, 2, 8'h10);
        add(0, 0, 1, 8'h12, 0,  1, 0, 2, 8'h10);
        add(0, 0, 0, 8'h00, 1,  1, 1, 1, 8'h11);
        add(0, 0, 0, 8'h00, 1,  0, 1, 0, 8'h00);
        // flush in TWO with simultaneous push
        add(0, 0, 1, 8'h30, 0,  1, 1, 1, 8'h30);
        add(0, 0, 1, 8'h31, 0,  1, 0, 2, 8'h30);
        add(0, 1, 1, 8'h20, 0,  0, 1, 0, 8'h00);
        add(0, 0, 0, 8'h00, 1,  0, 1, 0, 8'h00);
        // reset together with flush while in TWO
        add(0, 0, 1, 8'h40, 0,  1, 1, 1, 8'h40);
        add(0, 0, 1, 8'h41, 0,  1, 0, 2, 8'h40);
        add(1, 1, 1, 8'h42, 1,  0, 1, 0, 8'h00);
        add(0, 0, 0, 8'h00, 1,  0, 1, 0, 8'h00);
        // ONE with simultaneous push and pop, then stalled hold
        add(0, 0, 1, 8'h50, 0,  1, 1, 1, 8'h50);
        add(0, 0, 1, 8'h51, 1,  1, 1, 1, 8'h51);
        add(0, 0, 0, 8'h00, 0,  1, 1, 1, 8'h51);
        add(0, 0, 0, 8'h00, 0,  1, 1, 1, 8'h51);
        add(0, 0, 0, 8'h00, 1,  0, 1, 0, 8'h00);

        foreach (vq[i]) begin
            RST       = vq[i].rst;
            flush     = vq[i].fl;
            in_valid  = vq[i].iv;
            in_data   = W'(vq[i].d);
            out_ready = vq[i].ordy;
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d out_valid", i), W'(out_valid), W'(vq[i].ov));
            chk($sformatf("v%0d in_ready", i),  W'(in_ready),  W'(vq[i].ir));
            chk($sformatf("v%0d occupancy", i), W'(occupancy), W'(vq[i].occ));
            chk($sformatf("v%0d out_data", i),  out_data,      W'(vq[i].od));
        end

        // Randomized handshakes; buffer is empty here (last vector drained it).
        RST = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            flush     = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = {$urandom, $urandom, $urandom};

            chk("rnd occupancy", W'(occupancy), W'(model_q.size()));
            chk("rnd out_valid", W'(out_valid), W'(model_q.size() != 0));
            chk("rnd in_ready",  W'(in_ready),  W'(model_q.size() < 2));
            rdata = (model_q.size() != 0) ? model_q[0] : '0;
            chk("rnd out_data", out_data, rdata);

            m_in_fire  = in_valid && (model_q.size() < 2);
            m_out_fire = out_ready && (model_q.size() != 0);
            if (flush) begin
                model_q.delete();
            end else begin
                if (m_out_fire) void'(model_q.pop_front());
                if (m_in_fire)  model_q.push_back(in_data);
            end
            @(posedge CLK);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter WIDTH, default 96, payload width in bits (instr + pc + pc+4).
REQ-002 Parameter BUBBLE, default '0, value driven on out_data while out_valid=0.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all held entries at next edge (branch/jump squash).
REQ-006 in_valid  input  1  upstream (fetch) offers in_data.
REQ-007 in_ready  output  1  buffer can accept this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data holds a live entry.
REQ-010 out_ready  input  1  downstream (decode) consumes this cycle; deasserted = stall.
REQ-011 out_data  output  WIDTH  oldest held payload, else BUBBLE.
REQ-012 occupancy  output  2  number of held entries (0..2).

Function
REQ-013 Block SHALL be a 2-entry skid buffer: main entry (drives out_data) plus skid entry.
REQ-014 States SHALL be EMPTY (0 entries), ONE (main valid), TWO (main and skid valid).
REQ-015 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-016 in_ready SHALL depend on state only (1 unless TWO); no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 exactly in ONE and TWO; occupancy SHALL equal state count.
REQ-018 EMPTY: in_fire -> ONE, main<=in_data; else stay.
REQ-019 ONE: in_fire & out_fire -> ONE, main<=in_data; in_fire only -> TWO, skid<=in_data; out_fire only -> EMPTY; neither -> hold.
REQ-020 TWO: out_fire -> ONE, main<=skid; else hold (in_ready=0, input ignored).
REQ-021 Held entries SHALL not change while no fire occurs on their side (stall = exact hold).
REQ-022 Latency: data accepted at edge N SHALL appear on out_data with out_valid=1 after edge N.
REQ-023 With out_ready held 1, throughput SHALL be one entry per cycle with no bubbles.
REQ-024 Entries SHALL leave in acceptance order; none duplicated or dropped except by flush/RST.
REQ-025 flush SHALL override all transitions: next state EMPTY; any in_fire/out_fire that cycle is discarded from the buffer.
REQ-026 out_data SHALL equal BUBBLE whenever out_valid=0, including the cycle after flush.
REQ-027 Entry storage SHALL be WIDTH bits each; no truncation or extension of payload.

Reset
REQ-028 RST=1 at a rising edge SHALL force EMPTY, occupancy=0, out_valid=0, in_ready=1, out_data=BUBBLE.
REQ-029 RST SHALL take priority over flush and all handshakes, including mid-transfer in TWO.
REQ-030 Stored entry contents need not be cleared, but SHALL never be visible after reset.

Structure
REQ-031 cpu_types_pkg SHALL hold the state enum (EMPTY, ONE, TWO) and a fetch/decode payload struct (instr, pc, pcplusfour) whose width sets the WIDTH default.
REQ-032 Block SHALL be a single module; no sub-module; one state register, two WIDTH-bit data registers.

Verification
REQ-033 Reset: RST 1 for 2 cycles with in_valid=1, in_data=0xAA -> out_valid=0, in_ready=1, occupancy=0, out_data=0.
REQ-034 Streaming: out_ready=1, push 0x01..0x05 back-to-back -> out_data 0x01..0x05 on consecutive cycles, occupancy=1 throughout.
REQ-035 Stall/skid: out_ready=0, push 0x10, 0x11, 0x12 -> 0x10,0x11 held, in_ready=0 in TWO, 0x12 not accepted; release out_ready -> 0x10 then 0x11 in order.
REQ-036 Flush in TWO with simultaneous in_valid=1, data 0x20 -> next cycle EMPTY, out_valid=0, out_data=BUBBLE, 0x20 never output.
REQ-037 Mid-operation reset: in TWO assert RST and flush with out_ready=1 -> EMPTY next cycle, no entry emitted afterward.
REQ-038 Random handshake run, 10k cycles, scoreboard -> output sequence equals accepted input sequence between flushes.
